// File: rtl/kakacpu_pkg.sv
// Shared types and constants for the kakacpu execute stage.
package kakacpu_pkg;

  // Operation encoding; must match the decode stage's inst_type output.
  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpSll  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpSlt  = 4'd8,
    OpSltu = 4'd9,
    OpAddi = 4'd10,
    OpLui  = 4'd11,
    OpBeq  = 4'd12,
    OpBne  = 4'd13,
    OpJal  = 4'd14,
    OpMul  = 4'd15
  } exec_op_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssued = 2'd1,
    StMul    = 2'd2
  } state_t;

  // Link value for JAL is the address of the next sequential instruction.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute and execute-to-downstream signal bundle.
interface execute_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_input;
  logic            stall_output;
  logic [XLEN-1:0] pc_input;
  logic [4:0]      rd_input;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] immidiate_data;
  logic [3:0]      inst_type;
  logic            stall_input;
  logic            valid_output;
  logic [XLEN-1:0] result_data;
  logic [4:0]      rd_output;
  logic            branch_output;
  logic [XLEN-1:0] branch_dest_address;

  // Upstream/downstream side: drives instructions and the downstream stall.
  modport master (
    output valid_input, pc_input, rd_input, rs1_data, rs2_data, immidiate_data, inst_type,
    output stall_input,
    input  stall_output, valid_output, result_data, rd_output, branch_output,
    input  branch_dest_address
  );

  // Execute stage side.
  modport slave (
    input  valid_input, pc_input, rd_input, rs1_data, rs2_data, immidiate_data, inst_type,
    input  stall_input,
    output stall_output, valid_output, result_data, rd_output, branch_output,
    output branch_dest_address
  );
endinterface

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
module exec_mul #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_next;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy     = busy_q;
  // done marks the edge that performs the final iteration; product is that iteration's sum.
  assign done     = busy_q && (cnt_q == CntW'(MUL_CYCLES - 1));
  assign product  = acc_next;

  // Load operands on start, otherwise accumulate one partial product per cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/execute.sv
// Execute stage: combinational ALU, branch resolution, iterative multiply, registered result.
module execute
  import kakacpu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input logic      clk,
  input logic      rst,
  execute_if.slave bus
);
  state_t          state_q, state_d;
  logic            valid_q, valid_d, branch_q, branch_d;
  logic [XLEN-1:0] result_q, result_d, dest_q, dest_d;
  logic [4:0]      rd_q, rd_d, mul_rd_q, mul_rd_d;

  exec_op_t        op;
  logic [XLEN-1:0] op_b, alu_res, target, mul_product;
  logic            taken, no_rd, stall, accept, take;
  logic            mul_start, mul_busy, mul_done;

  assign op     = exec_op_t'(bus.inst_type);
  assign stall  = (state_q == StMul) || (valid_q && bus.stall_input);
  assign accept = bus.valid_input && !stall;
  // Anything accepted while the redirect pulse is out is wrong-path and is dropped.
  assign take   = accept && !branch_q;
  assign target = bus.pc_input + bus.immidiate_data;

  // ALU and branch resolution.
  always_comb begin
    op_b    = (op == OpAddi || op == OpLui) ? bus.immidiate_data : bus.rs2_data;
    alu_res = '0;
    taken   = 1'b0;
    no_rd   = 1'b0;
    case (op)
      OpAdd, OpAddi: alu_res = bus.rs1_data + op_b;
      OpSub:  alu_res = bus.rs1_data - op_b;
      OpAnd:  alu_res = bus.rs1_data & op_b;
      OpOr:   alu_res = bus.rs1_data | op_b;
      OpXor:  alu_res = bus.rs1_data ^ op_b;
      OpSll:  alu_res = bus.rs1_data << bus.rs2_data[4:0];
      OpSrl:  alu_res = bus.rs1_data >> bus.rs2_data[4:0];
      OpSra:  alu_res = $signed(bus.rs1_data) >>> bus.rs2_data[4:0];
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1_data) < $signed(op_b)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, bus.rs1_data < op_b};
      OpLui:  alu_res = bus.immidiate_data;
      OpBeq: begin
        taken = (bus.rs1_data == bus.rs2_data);
        no_rd = 1'b1;
      end
      OpBne: begin
        taken = (bus.rs1_data != bus.rs2_data);
        no_rd = 1'b1;
      end
      OpJal: begin
        alu_res = bus.pc_input + XLEN'(PC_STEP);
        taken   = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // FSM next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    result_d  = result_q;
    rd_d      = rd_q;
    dest_d    = dest_q;
    mul_rd_d  = mul_rd_q;
    branch_d  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      StMul: begin
        if (mul_done) begin
          state_d  = StIssued;
          valid_d  = 1'b1;
          result_d = mul_product;
          rd_d     = mul_rd_q;
        end else if (!mul_busy) begin
          // Defensive: never sit in StMul without a running multiply.
          state_d = StIdle;
        end
      end
      default: begin
        if (valid_q && bus.stall_input) begin
          // Downstream busy: hold result, rd and valid.
        end else if (take && op == OpMul) begin
          state_d   = StMul;
          valid_d   = 1'b0;
          mul_start = 1'b1;
          mul_rd_d  = bus.rd_input;
        end else if (take) begin
          state_d  = StIssued;
          valid_d  = 1'b1;
          result_d = alu_res;
          rd_d     = no_rd ? 5'd0 : bus.rd_input;
          branch_d = taken;
          if (taken) dest_d = target;
        end else begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      dest_q   <= '0;
      mul_rd_q <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      dest_q   <= dest_d;
      mul_rd_q <= mul_rd_d;
      branch_q <= branch_d;
    end
  end

  exec_mul #(
    .XLEN      (XLEN),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (bus.rs1_data),
    .b      (bus.rs2_data),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  assign bus.stall_output        = stall;
  assign bus.valid_output        = valid_q;
  assign bus.result_data         = result_q;
  assign bus.rd_output           = rd_q;
  assign bus.branch_output       = branch_q;
  assign bus.branch_dest_address = dest_q;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: opcode vector table plus multi-cycle sequences.
module tb_execute;
  import kakacpu_pkg::*;

  typedef struct {
    exec_op_t    op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    logic        exp_br;
    logic [31:0] exp_dest;
  } vec_t;

  localparam int NV = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t vecs [NV];

  execute_if #(.XLEN(32)) bus ();

  execute #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input exec_op_t op, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd);
    bus.valid_input    = v;
    bus.inst_type      = op;
    bus.rs1_data       = rs1;
    bus.rs2_data       = rs2;
    bus.immidiate_data = imm;
    bus.pc_input       = pc;
    bus.rd_input       = rd;
  endtask

  function automatic vec_t mk(input exec_op_t op, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                              input logic [31:0] er, input logic [4:0] erd, input logic eb,
                              input logic [31:0] ed);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc; v.rd = rd;
    v.exp_res = er; v.exp_rd = erd; v.exp_br = eb; v.exp_dest = ed;
    return v;
  endfunction

  initial begin
    int  stall_cnt;
    bit  early;
    n_cmp = 0;
    n_err = 0;

    vecs[0]  = mk(OpAdd,  32'd5,          32'd7,          32'd0,          32'h0,   5'd3,
                  32'd12,         5'd3,  1'b0, 32'h0);
    vecs[1]  = mk(OpSub,  32'd3,          32'd5,          32'd0,          32'h0,   5'd4,
                  32'hFFFF_FFFE,  5'd4,  1'b0, 32'h0);
    vecs[2]  = mk(OpSlt,  32'd3,          32'd5,          32'd0,          32'h0,   5'd5,
                  32'd1,          5'd5,  1'b0, 32'h0);
    vecs[3]  = mk(OpSltu, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'h0,   5'd6,
                  32'd0,          5'd6,  1'b0, 32'h0);
    vecs[4]  = mk(OpSlt,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'h0,   5'd6,
                  32'd1,          5'd6,  1'b0, 32'h0);
    vecs[5]  = mk(OpAnd,  32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h0,   5'd7,
                  32'h0000_F000,  5'd7,  1'b0, 32'h0);
    vecs[6]  = mk(OpOr,   32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h0,   5'd8,
                  32'h0000_FFF0,  5'd8,  1'b0, 32'h0);
    vecs[7]  = mk(OpXor,  32'h0000_F0F0,  32'h0000_FF00,  32'd0,          32'h0,   5'd9,
                  32'h0000_0FF0,  5'd9,  1'b0, 32'h0);
    vecs[8]  = mk(OpSll,  32'd1,          32'h0000_0024,  32'd0,          32'h0,   5'd10,
                  32'h0000_0010,  5'd10, 1'b0, 32'h0);
    vecs[9]  = mk(OpSrl,  32'h8000_0000,  32'd4,          32'd0,          32'h0,   5'd11,
                  32'h0800_0000,  5'd11, 1'b0, 32'h0);
    vecs[10] = mk(OpSra,  32'h8000_0000,  32'd4,          32'd0,          32'h0,   5'd12,
                  32'hF800_0000,  5'd12, 1'b0, 32'h0);
    vecs[11] = mk(OpAddi, 32'd10,         32'd100,        32'hFFFF_FFFF,  32'h0,   5'd13,
                  32'd9,          5'd13, 1'b0, 32'h0);
    vecs[12] = mk(OpLui,  32'd1,          32'd2,          32'h1234_5000,  32'h0,   5'd14,
                  32'h1234_5000,  5'd14, 1'b0, 32'h0);
    vecs[13] = mk(OpBne,  32'd1,          32'd1,          32'h10,         32'h80,  5'd7,
                  32'd0,          5'd0,  1'b0, 32'h0);
    vecs[14] = mk(OpBne,  32'd1,          32'd2,          32'hFFFF_FFF0,  32'h200, 5'd7,
                  32'd0,          5'd0,  1'b1, 32'h1F0);
    vecs[15] = mk(OpJal,  32'd0,          32'd0,          32'h100,        32'h40,  5'd1,
                  32'h44,         5'd1,  1'b1, 32'h140);

    // Reset state
    rst = 1'b1;
    bus.stall_input = 1'b0;
    drive(1'b0, OpAdd, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    step();
    check("reset valid_output", 32'(bus.valid_output), 32'd0);
    check("reset stall_output", 32'(bus.stall_output), 32'd0);
    check("reset result_data", bus.result_data, 32'd0);
    check("reset branch_output", 32'(bus.branch_output), 32'd0);
    rst = 1'b0;

    // Single-cycle opcode table
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc, vecs[i].rd);
      step();
      check($sformatf("v%0d valid", i), 32'(bus.valid_output), 32'd1);
      check($sformatf("v%0d result", i), bus.result_data, vecs[i].exp_res);
      check($sformatf("v%0d rd", i), 32'(bus.rd_output), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d branch", i), 32'(bus.branch_output), 32'(vecs[i].exp_br));
      if (vecs[i].exp_br) check($sformatf("v%0d dest", i), bus.branch_dest_address,
                                vecs[i].exp_dest);
      bus.valid_input = 1'b0;
      step();
      check($sformatf("v%0d idle valid", i), 32'(bus.valid_output), 32'd0);
      check($sformatf("v%0d idle branch", i), 32'(bus.branch_output), 32'd0);
      if (vecs[i].exp_br) check($sformatf("v%0d dest hold", i), bus.branch_dest_address,
                                vecs[i].exp_dest);
    end

    // Back-to-back throughput
    drive(1'b1, OpAdd, 32'd1, 32'd2, 32'd0, 32'd0, 5'd2);
    step();
    drive(1'b1, OpSub, 32'd10, 32'd4, 32'd0, 32'd0, 5'd3);
    step();
    check("b2b valid", 32'(bus.valid_output), 32'd1);
    check("b2b result", bus.result_data, 32'd6);
    check("b2b rd", 32'(bus.rd_output), 32'd3);
    bus.valid_input = 1'b0;
    step();

    // Multiply with ignored valid pulses during the busy window
    drive(1'b1, OpMul, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 32'd0, 5'd9);
    step();
    stall_cnt = 0;
    early = 1'b0;
    if (bus.stall_output) stall_cnt++;
    if (bus.valid_output) early = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      drive((k < 31) ? 1'(k % 2) : 1'b0, OpAdd, 32'd1, 32'd1, 32'd0, 32'd0, 5'd5);
      step();
      if (k < 32) begin
        if (bus.stall_output) stall_cnt++;
        if (bus.valid_output) early = 1'b1;
      end
    end
    check("mul stall cycles", 32'(stall_cnt), 32'd32);
    check("mul no early valid", 32'(early), 32'd0);
    check("mul valid", 32'(bus.valid_output), 32'd1);
    check("mul result", bus.result_data, 32'hFFFE_0001);
    check("mul rd", 32'(bus.rd_output), 32'd9);
    check("mul stall released", 32'(bus.stall_output), 32'd0);
    step();
    check("mul busy pulses dropped", 32'(bus.valid_output), 32'd0);

    // Taken BEQ and shadow squash of the following ADD
    drive(1'b1, OpBeq, 32'd5, 32'd5, 32'h20, 32'h100, 5'd2);
    step();
    check("beq branch", 32'(bus.branch_output), 32'd1);
    check("beq dest", bus.branch_dest_address, 32'h120);
    check("beq result", bus.result_data, 32'd0);
    check("beq rd", 32'(bus.rd_output), 32'd0);
    drive(1'b1, OpAdd, 32'd1, 32'd1, 32'd0, 32'd0, 5'd5);
    step();
    check("squash valid", 32'(bus.valid_output), 32'd0);
    check("squash branch", 32'(bus.branch_output), 32'd0);
    check("squash dest hold", bus.branch_dest_address, 32'h120);
    bus.valid_input = 1'b0;
    step();
    check("squash stays dropped", 32'(bus.valid_output), 32'd0);

    // Downstream stall holds the result for three cycles
    drive(1'b1, OpAdd, 32'd20, 32'd22, 32'd0, 32'd0, 5'd6);
    step();
    check("hold first valid", 32'(bus.valid_output), 32'd1);
    drive(1'b1, OpAdd, 32'd1, 32'd1, 32'd0, 32'd0, 5'd7);
    bus.stall_input = 1'b1;
    #1;
    check("hold stall_output now", 32'(bus.stall_output), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hold%0d valid", c), 32'(bus.valid_output), 32'd1);
      check($sformatf("hold%0d result", c), bus.result_data, 32'd42);
      check($sformatf("hold%0d rd", c), 32'(bus.rd_output), 32'd6);
      check($sformatf("hold%0d stall", c), 32'(bus.stall_output), 32'd1);
      check($sformatf("hold%0d branch", c), 32'(bus.branch_output), 32'd0);
    end
    bus.stall_input = 1'b0;
    step();
    check("post-hold result", bus.result_data, 32'd2);
    check("post-hold rd", 32'(bus.rd_output), 32'd7);
    bus.valid_input = 1'b0;
    step();

    // Asynchronous reset at multiply iteration 10
    drive(1'b1, OpMul, 32'd3, 32'd4, 32'd0, 32'd0, 5'd8);
    step();
    bus.valid_input = 1'b0;
    repeat (10) step();
    #2;
    rst = 1'b1;
    #1;
    check("rst valid", 32'(bus.valid_output), 32'd0);
    check("rst result", bus.result_data, 32'd0);
    check("rst rd", 32'(bus.rd_output), 32'd0);
    check("rst dest", bus.branch_dest_address, 32'd0);
    check("rst stall", 32'(bus.stall_output), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, OpAdd, 32'd2, 32'd3, 32'd0, 32'd0, 5'd1);
    step();
    check("after rst valid", 32'(bus.valid_output), 32'd1);
    check("after rst result", bus.result_data, 32'd5);
    check("after rst rd", 32'(bus.rd_output), 32'd1);
    bus.valid_input = 1'b0;
    early = 1'b0;
    repeat (40) begin
      step();
      if (bus.valid_output || bus.stall_output) early = 1'b1;
    end
    check("aborted mul silent", 32'(early), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the kakacpu pipeline. It sits directly downstream of `decode` and consumes decode's operand, immediate and instruction-type outputs. It computes an ALU result, or runs a 32-cycle iterative multiply. It resolves branches and jumps, returning a redirect to `fetch`, and presents a registered result with valid/stall handshaking toward the following stage.

## Interface
- `XLEN`, default 32: data and address width.
- `MUL_CYCLES`, default 32: number of multiply iterations. Must equal `XLEN`.

Ports:
- `clk`  in  1: pipeline clock.
- `rst`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `valid_input`  in  1: decode presents a valid instruction.
- `stall_output`  out  1: execute cannot accept; decode must hold its outputs.
- `pc_input`  in  XLEN: PC of the presented instruction.
- `rd_input`  in  5: destination register index.
- `rs1_data`, `rs2_data`  in  XLEN: source operands.
- `immidiate_data`  in  XLEN: sign-extended immediate.
- `inst_type`  in  4: operation code, encoded as `exec_op_t`.
- `stall_input`  in  1: downstream is busy; hold the current result.
- `valid_output`  out  1: `result_data` and `rd_output` are valid.
- `result_data`  out  XLEN: operation result.
- `rd_output`  out  5: destination index of the result.
- `branch_output`  out  1: one-cycle redirect pulse to `fetch`.
- `branch_dest_address`  out  XLEN: redirect target.

## Operation
- Opcodes 0–15: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, ADDI, LUI, BEQ, BNE, JAL, MUL.
- Operand B is `immidiate_data` for ADDI and LUI, and `rs2_data` otherwise.
- LUI result is `immidiate_data`.
- Shift amount is `rs2_data[4:0]`.
- SLT compares signed; SLTU compares unsigned.
- All arithmetic is modulo 2^XLEN; carries are discarded.
- BEQ and BNE: taken when `rs1_data` ==/!= `rs2_data`. Target is `pc_input + immidiate_data`. Result is 0 and `rd_output` is 0.
- JAL: always taken. Target is `pc_input + immidiate_data`. Result is `pc_input + 4`.
- MUL: shift-add over `MUL_CYCLES` iterations. Result is the low XLEN bits of the unsigned product.
- An instruction is accepted on a rising edge where `valid_input && !stall_output`.
- FSM states:
  - IDLE → ISSUED: on accept of a non-MUL op.
  - IDLE → MUL: on accept of MUL. Latch operands and clear the iteration counter.
  - ISSUED → ISSUED: on a new accept while not stalled.
  - ISSUED → IDLE: when there is no accept and `stall_input` is low.
  - MUL → MUL: while the counter is below `MUL_CYCLES-1`.
  - MUL → ISSUED: on the final iteration, with the product registered.
- `stall_output = (state==MUL) || (valid_output && stall_input)`.
- While `valid_output && stall_input`: `result_data`, `rd_output` and `valid_output` hold unchanged.
- `branch_output` is high for exactly one cycle, the first cycle of the taken instruction's `valid_output`. It is not re-pulsed while that result is held.
- Shadow squash: an instruction accepted in the same cycle `branch_output` is high is consumed and discarded. It produces no `valid_output`.
- Reset, including mid-MUL, clears all outputs to 0 and sets the FSM to IDLE. A multiply in progress is aborted and produces no result.

## Timing
- Single-cycle ops:
  - Accept on edge N; `valid_output` is high after edge N.
  - Latency is 1 cycle. Throughput is 1 per cycle when `stall_input` is low.
- MUL:
  - Accept on edge N; `stall_output` is high from after edge N through edge N+31.
  - `valid_output` rises after edge N+32, so latency is 32 cycles.
- `branch_dest_address` is valid while `branch_output` is high, and holds its last value otherwise.
- Outputs are registered. `stall_output` is combinational from state and `stall_input`.

## Structure
- Package `kakacpu_pkg` holds:
  - `exec_op_t`, a 4-bit enum matching the decode encoding;
  - `state_t` (IDLE, ISSUED, MUL);
  - the constant `PC_STEP = 4`.
- Sub-module `exec_mul`: iterative shift-add multiplier.
  - Ports: `clk`, `rst`, `start`, `a`, `b`, `busy`, `done`, `product`.
- The ALU is combinational within `execute`.

## Test plan
- ADD with `rs1_data=5`, `rs2_data=7`, `rd_input=3` → one cycle later: `valid_output=1`, `result_data=12`, `rd_output=3`.
- SUB 3−5 → `result_data=0xFFFFFFFE`. SLT on the same operands → 1. SLTU with `rs1_data=0xFFFFFFFF`, `rs2_data=1` → 0.
- MUL 0xFFFF × 0xFFFF → `stall_output` high for 32 cycles, then `result_data=0xFFFE0001`. `valid_input` pulses during the busy window are not accepted.
- BEQ taken with `pc_input=0x100`, `imm=0x20`, equal operands → `branch_output` pulses one cycle with `branch_dest_address=0x120`. An ADD presented in that cycle produces no `valid_output`.
- Hold `stall_input=1` for 3 cycles after an ADD result → the result holds unchanged, `stall_output=1`, and `branch_output` is not repeated.
- Assert `rst` at iteration 10 of a MUL → all outputs 0 immediately. After release, a new ADD completes normally with 1-cycle latency.
